// File: rtl/return_addr_stack_pkg.sv
// Shared constants and operation encoding for the return-address stack.
// The top decodes fetch/retire flags into one ras_op_e per stack unit.
package return_addr_stack_pkg;

  localparam int RAS_ADDR_WIDTH = 22;
  localparam int RAS_DEPTH      = 8;
  localparam int RAS_PTR_WIDTH  = $clog2(RAS_DEPTH);
  // Return lands after the delay slot.
  localparam int RAS_RET_OFFSET = 2;

  typedef enum logic [1:0] {
    RAS_NONE    = 2'd0,
    RAS_PUSH    = 2'd1,
    RAS_POP     = 2'd2,
    RAS_REPLACE = 2'd3
  } ras_op_e;

  function automatic ras_op_e ras_decode(input logic push, input logic pop);
    ras_op_e op;
    unique case ({push, pop})
      2'b10:   op = RAS_PUSH;
      2'b01:   op = RAS_POP;
      2'b11:   op = RAS_REPLACE;
      default: op = RAS_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/return_addr_stack_if.sv
// Fetch/retire notification bundle into the return-address stack and its prediction outputs.
// There is no back-pressure: i_valid qualifies the fetch-side flags for one cycle, and the commit flags are self-qualifying.
interface return_addr_stack_if #(
  parameter int ADDRESS_WIDTH = 22
);

  logic                     i_valid;
  logic                     i_jal_inst;
  logic                     i_jr_inst;
  logic                     i_j_inst;
  logic [ADDRESS_WIDTH-1:0] i_branch_address;
  logic                     i_commit_push;
  logic                     i_commit_pop;
  logic [ADDRESS_WIDTH-1:0] i_commit_address;
  logic                     i_flush;
  logic [ADDRESS_WIDTH-1:0] o_ras_target;
  logic                     o_ras_hit;
  logic                     o_ras_empty;

  modport master (
    output i_valid, i_jal_inst, i_jr_inst, i_j_inst, i_branch_address,
    output i_commit_push, i_commit_pop, i_commit_address, i_flush,
    input  o_ras_target, o_ras_hit, o_ras_empty
  );

  modport slave (
    input  i_valid, i_jal_inst, i_jr_inst, i_j_inst, i_branch_address,
    input  i_commit_push, i_commit_pop, i_commit_address, i_flush,
    output o_ras_target, o_ras_hit, o_ras_empty
  );

endinterface

// File: rtl/return_addr_stack_ras_ptr.sv
// One circular stack: top-of-stack pointer, saturating occupancy count and entry storage.
// Next-state values are exported so a second unit can load this unit's post-update state in the same cycle.
module ras_ptr
  import return_addr_stack_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RAS_ADDR_WIDTH,
  parameter int DEPTH         = RAS_DEPTH,
  parameter int PTR_WIDTH     = $clog2(DEPTH)
) (
  input  logic                                i_Clk,
  input  logic                                i_Reset_n,
  input  ras_op_e                             op,
  input  logic [ADDRESS_WIDTH-1:0]            ret_addr,
  input  logic                                load,
  input  logic [PTR_WIDTH-1:0]                load_tos,
  input  logic [PTR_WIDTH:0]                  load_count,
  input  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] load_mem,
  output logic [PTR_WIDTH-1:0]                tos_q,
  output logic [PTR_WIDTH:0]                  count_q,
  output logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] mem_q,
  output logic [PTR_WIDTH-1:0]                tos_d,
  output logic [PTR_WIDTH:0]                  count_d,
  output logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] mem_d
);

  localparam logic [PTR_WIDTH:0] COUNT_FULL = (PTR_WIDTH+1)'(DEPTH);

  logic [PTR_WIDTH-1:0] tos_inc;
  logic                 is_empty;

  assign tos_inc  = tos_q + PTR_WIDTH'(1);
  assign is_empty = (count_q == '0);

  always_comb begin
    tos_d   = tos_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (load) begin
      tos_d   = load_tos;
      count_d = load_count;
      mem_d   = load_mem;
    end else begin
      unique case (op)
        RAS_PUSH: begin
          // Pointer wrap overwrites the oldest entry once full.
          tos_d          = tos_inc;
          mem_d[tos_inc] = ret_addr;
          if (count_q != COUNT_FULL) count_d = count_q + (PTR_WIDTH+1)'(1);
        end
        RAS_POP: begin
          if (!is_empty) begin
            tos_d   = tos_q - PTR_WIDTH'(1);
            count_d = count_q - (PTR_WIDTH+1)'(1);
          end
        end
        RAS_REPLACE: begin
          mem_d[tos_q] = ret_addr;
          if (is_empty) count_d = (PTR_WIDTH+1)'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      tos_q   <= '0;
      count_q <= '0;
      mem_q   <= '0;
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/return_addr_stack.sv
// Speculative return-address stack with a committed shadow copy used to repair fetch state on flush.
// Prediction is combinational from the speculative top of stack, so a jr gets its target in the cycle it is flagged.
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RAS_ADDR_WIDTH,
  parameter int DEPTH         = RAS_DEPTH,
  parameter int PTR_WIDTH     = $clog2(DEPTH)
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset_n,
  return_addr_stack_if.slave   bus
);

  ras_op_e spec_op;
  ras_op_e com_op;

  logic [ADDRESS_WIDTH-1:0] spec_ret_addr;
  logic [ADDRESS_WIDTH-1:0] com_ret_addr;

  logic [PTR_WIDTH-1:0]                spec_tos_q;
  logic [PTR_WIDTH:0]                  spec_count_q;
  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] spec_mem_q;

  logic [PTR_WIDTH-1:0]                com_tos_d;
  logic [PTR_WIDTH:0]                  com_count_d;
  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] com_mem_d;

  logic [PTR_WIDTH-1:0]                unused_spec_tos_d;
  logic [PTR_WIDTH:0]                  unused_spec_count_d;
  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] unused_spec_mem_d;
  logic [PTR_WIDTH-1:0]                unused_com_tos_q;
  logic [PTR_WIDTH:0]                  unused_com_count_q;
  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] unused_com_mem_q;
  logic                                unused_j_inst;

  logic spec_empty;

  // Plain j has no stack effect.
  assign unused_j_inst = bus.i_j_inst;

  assign spec_ret_addr = bus.i_branch_address + ADDRESS_WIDTH'(RAS_RET_OFFSET);
  assign com_ret_addr  = bus.i_commit_address + ADDRESS_WIDTH'(RAS_RET_OFFSET);

  always_comb begin
    spec_op = RAS_NONE;
    if (bus.i_valid && !bus.i_flush) spec_op = ras_decode(bus.i_jal_inst, bus.i_jr_inst);
  end

  assign com_op = ras_decode(bus.i_commit_push, bus.i_commit_pop);

  ras_ptr #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DEPTH         (DEPTH),
    .PTR_WIDTH     (PTR_WIDTH)
  ) u_com (
    .i_Clk      (i_Clk),
    .i_Reset_n  (i_Reset_n),
    .op         (com_op),
    .ret_addr   (com_ret_addr),
    .load       (1'b0),
    .load_tos   ('0),
    .load_count ('0),
    .load_mem   ('0),
    .tos_q      (unused_com_tos_q),
    .count_q    (unused_com_count_q),
    .mem_q      (unused_com_mem_q),
    .tos_d      (com_tos_d),
    .count_d    (com_count_d),
    .mem_d      (com_mem_d)
  );

  // Flush loads the committed state including this cycle's retire update.
  ras_ptr #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DEPTH         (DEPTH),
    .PTR_WIDTH     (PTR_WIDTH)
  ) u_spec (
    .i_Clk      (i_Clk),
    .i_Reset_n  (i_Reset_n),
    .op         (spec_op),
    .ret_addr   (spec_ret_addr),
    .load       (bus.i_flush),
    .load_tos   (com_tos_d),
    .load_count (com_count_d),
    .load_mem   (com_mem_d),
    .tos_q      (spec_tos_q),
    .count_q    (spec_count_q),
    .mem_q      (spec_mem_q),
    .tos_d      (unused_spec_tos_d),
    .count_d    (unused_spec_count_d),
    .mem_d      (unused_spec_mem_d)
  );

  assign spec_empty       = (spec_count_q == '0);
  assign bus.o_ras_empty  = spec_empty;
  assign bus.o_ras_hit    = bus.i_valid & bus.i_jr_inst & !spec_empty;
  assign bus.o_ras_target = spec_empty ? '0 : spec_mem_q[spec_tos_q];

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack: inputs change on the falling edge and outputs are sampled 1ns later.
// Expected values are hand-computed; the overflow sequence keeps its expectations in a queue.
module tb_return_addr_stack;

  localparam int AW = 22;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [AW-1:0] exp_q[$];

  return_addr_stack_if #(.ADDRESS_WIDTH(AW)) ras_if ();

  return_addr_stack #(
    .ADDRESS_WIDTH (AW),
    .DEPTH         (8)
  ) dut (
    .i_Clk     (clk),
    .i_Reset_n (rst_n),
    .bus       (ras_if.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [AW-1:0] tgt, input logic hit, input logic empty);
    check({tag, "_target"}, 32'(ras_if.o_ras_target), 32'(tgt));
    check({tag, "_hit"},    32'(ras_if.o_ras_hit),    32'(hit));
    check({tag, "_empty"},  32'(ras_if.o_ras_empty),  32'(empty));
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic jal, input logic jr, input logic [AW-1:0] a,
                       input logic cpush, input logic cpop, input logic [AW-1:0] ca, input logic fl);
    @(negedge clk);
    ras_if.i_valid          = v;
    ras_if.i_jal_inst       = jal;
    ras_if.i_jr_inst        = jr;
    ras_if.i_j_inst         = 1'b0;
    ras_if.i_branch_address = a;
    ras_if.i_commit_push    = cpush;
    ras_if.i_commit_pop     = cpop;
    ras_if.i_commit_address = ca;
    ras_if.i_flush          = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_jal(input logic [AW-1:0] a);
    drive(1'b1, 1'b1, 1'b0, a, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_jr(input logic [AW-1:0] a);
    drive(1'b1, 1'b0, 1'b1, a, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_commit(input logic cpush, input logic cpop, input logic [AW-1:0] ca);
    drive(1'b0, 1'b0, 1'b0, '0, cpush, cpop, ca, 1'b0);
  endtask

  task automatic do_flush();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    ras_if.i_valid          = 1'b0;
    ras_if.i_jal_inst       = 1'b0;
    ras_if.i_jr_inst        = 1'b0;
    ras_if.i_j_inst         = 1'b0;
    ras_if.i_branch_address = '0;
    ras_if.i_commit_push    = 1'b0;
    ras_if.i_commit_pop     = 1'b0;
    ras_if.i_commit_address = '0;
    ras_if.i_flush          = 1'b0;

    // Reset, idle (one idle carries an unqualified jal), then jr on empty
    idle();
    idle();
    release_reset();
    idle();
    drive(1'b0, 1'b1, 1'b0, 22'h000123, 1'b0, 1'b0, '0, 1'b0);
    idle();
    do_jr(22'h000300);
    chk_out("reset", 22'h0, 1'b0, 1'b1);

    // Single jal then jr
    do_jal(22'h000100);
    chk_out("jal_cycle", 22'h0, 1'b0, 1'b1);
    do_jr(22'h000300);
    chk_out("jr_pred", 22'h000102, 1'b1, 1'b0);
    idle();
    chk_out("after_jr", 22'h0, 1'b0, 1'b1);

    // Overflow: 10 pushes into 8 entries, then 9 pops
    for (int i = 0; i < 10; i++) begin
      do_jal(AW'(16 + i));
      exp_q.push_back(AW'(18 + i));
    end
    for (int i = 0; i < 8; i++) begin
      do_jr(22'h0);
      check($sformatf("ovf_pop%0d_target", i), 32'(ras_if.o_ras_target), 32'(exp_q.pop_back()));
      check($sformatf("ovf_pop%0d_hit", i), 32'(ras_if.o_ras_hit), 32'd1);
    end
    exp_q.delete();
    do_jr(22'h0);
    chk_out("ovf_underflow", 22'h0, 1'b0, 1'b1);

    // Return address wraps
    do_jal(22'h3FFFFF);
    do_jr(22'h0);
    chk_out("wrap", 22'h000001, 1'b1, 1'b0);
    idle();
    chk_out("wrap_after", 22'h0, 1'b0, 1'b1);

    // Commit, speculate, then flush with a concurrent commit and a discarded jal
    do_commit(1'b1, 1'b0, 22'h000040);
    chk_out("commit_no_spec", 22'h0, 1'b0, 1'b1);
    do_jal(22'h000050);
    do_jal(22'h000060);
    do_jr(22'h0);
    chk_out("spec_jr", 22'h000062, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 22'h000080, 1'b1, 1'b0, 22'h000070, 1'b1);
    idle();
    chk_out("flush_tos", 22'h000072, 1'b0, 1'b0);
    do_jr(22'h0);
    chk_out("flush_pop1", 22'h000072, 1'b1, 1'b0);
    do_jr(22'h0);
    chk_out("flush_pop2", 22'h000042, 1'b1, 1'b0);
    idle();
    chk_out("flush_drained", 22'h0, 1'b0, 1'b1);
    do_flush();
    idle();
    chk_out("reflush", 22'h000072, 1'b0, 1'b0);

    // Same-cycle jal+jr on a one-entry stack, then on an empty stack
    rst_n = 1'b0;
    idle();
    release_reset();
    do_jal(22'h000100);
    drive(1'b1, 1'b1, 1'b1, 22'h000200, 1'b0, 1'b0, '0, 1'b0);
    chk_out("repl_cycle", 22'h000102, 1'b1, 1'b0);
    idle();
    chk_out("repl_after", 22'h000202, 1'b0, 1'b0);
    do_jr(22'h0);
    chk_out("repl_pop", 22'h000202, 1'b1, 1'b0);
    idle();
    chk_out("repl_count1", 22'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 22'h000200, 1'b0, 1'b0, '0, 1'b0);
    chk_out("repl_empty_cycle", 22'h0, 1'b0, 1'b1);
    idle();
    chk_out("repl_empty_after", 22'h000202, 1'b0, 1'b0);
    do_jr(22'h0);
    idle();
    chk_out("repl_empty_count1", 22'h0, 1'b0, 1'b1);

    // Committed push / replace / pop, restored by flush
    do_commit(1'b1, 1'b0, 22'h000500);
    do_commit(1'b1, 1'b0, 22'h000600);
    do_commit(1'b1, 1'b1, 22'h000700);
    do_commit(1'b0, 1'b1, 22'h0);
    do_flush();
    idle();
    chk_out("com_ops_flush", 22'h000502, 1'b0, 1'b0);

    // Reset overrides concurrent jal, commit and flush
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 22'h000900, 1'b1, 1'b0, 22'h000900, 1'b1);
    release_reset();
    idle();
    chk_out("midreset", 22'h0, 1'b0, 1'b1);
    do_flush();
    idle();
    chk_out("midreset_flush", 22'h0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
